hilo_div: RTL and testbench
===========================

HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: we_i  input  1  HI/LO write enable from write-back stage.
REQ-004 SHALL have port: hi_i  input  32  value to write to HI.
REQ-005 SHALL have port: lo_i  input  32  value to write to LO.
REQ-006 SHALL have port: hi_o  output  32  current HI register value.
REQ-007 SHALL have port: lo_o  output  32  current LO register value.
REQ-008 SHALL have port: div_start_i  input  1  divide request from execute stage; held high until result consumed.
REQ-009 SHALL have port: div_annul_i  input  1  cancel an in-flight divide.
REQ-010 SHALL have port: signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned).
REQ-011 SHALL have port: opdata1_i  input  32  dividend.
REQ-012 SHALL have port: opdata2_i  input  32  divisor.
REQ-013 SHALL have port: div_result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-014 SHALL have port: div_ready_o  output  1  result valid.
REQ-015 SHALL have port: busy_o  output  1  stall request to pipeline control.

Function
REQ-016 SHALL update HI<=hi_i and LO<=lo_i at the clock edge when we_i=1; hi_o/lo_o SHALL be the register contents, no bypass (execute stage forwards).
REQ-017 SHALL implement divider FSM with states IDLE, BYZERO, ON, END.
REQ-018 IDLE: on div_start_i=1 and div_annul_i=0, go to BYZERO if opdata2_i==0, else latch |opdata1_i|, |opdata2_i| (magnitudes only when signed_div_i=1), clear 6-bit counter, go to ON.
REQ-019 ON: each cycle with counter<32 SHALL perform one restoring shift-subtract step and increment counter.
REQ-020 ON with counter==32: apply sign fix, load div_result_o, go to END; total 33 ON cycles, div_ready_o high 34 cycles after start sampled.
REQ-021 Signed fix: quotient negated if operand signs differ; remainder takes sign of dividend.
REQ-022 BYZERO: load div_result_o=0, go to END next edge (div_ready_o high 2 cycles after start sampled).
REQ-023 END: div_ready_o=1, div_result_o held; when div_start_i=0, go to IDLE, clear div_ready_o and div_result_o.
REQ-024 div_annul_i=1 in ON or BYZERO SHALL return to IDLE next edge with no result; div_annul_i in END SHALL be ignored.
REQ-025 Operands SHALL be sampled only in IDLE; changes during ON SHALL have no effect.
REQ-026 busy_o SHALL be combinational: 1 in ON or BYZERO, or in IDLE with div_start_i=1 and div_annul_i=0; 0 in END and otherwise.
REQ-027 HI/LO writes and divider operation SHALL be independent; simultaneous we_i and any divider event SHALL both take effect.

Reset
REQ-028 On rst=1 at a clock edge: HI=0, LO=0, state=IDLE, counter=0, div_result_o=0, div_ready_o=0; rst SHALL override we_i and div_start_i.
REQ-029 rst asserted mid-divide SHALL abort the operation with no result.

Configuration
REQ-030 With macro HILO_DIV_EN defined, divider SHALL be present as specified.
REQ-031 Without HILO_DIV_EN: HI/LO registers only; div_result_o=0, div_ready_o=0, busy_o=0 constantly; divider inputs ignored.

Verification
REQ-032 we_i=1, hi_i=0x12345678, lo_i=0x9ABCDEF0 -> next cycle hi_o=0x12345678, lo_o=0x9ABCDEF0; then rst -> both 0.
REQ-033 DIVU 100/7 held -> div_ready_o after 34 cycles, div_result_o={0x00000002,0x0000000E}, busy_o high until END.
REQ-034 DIV -7/2 -> div_result_o={0xFFFFFFFF,0xFFFFFFFD}; DIV 7/-2 -> {0x00000001,0xFFFFFFFD}.
REQ-035 DIV 5/0 -> div_ready_o after 2 cycles, div_result_o=0; drop start -> IDLE, ready 0.
REQ-036 Annul at ON counter=10 -> IDLE next edge, div_ready_o never asserts; new DIVU 9/3 then gives {0,3}.
REQ-037 we_i pulse during ON -> HI/LO updated, divide result unaffected.

Source files
------------

// File: rtl/hilo_div.sv
// hilo_div: HI/LO special registers plus an optional iterative divider.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   we_i, hi_i, lo_i   - HI/LO write from write-back
//   hi_o, lo_o         - HI/LO register contents (no bypass)
//   div_start_i        - divide request, held until result consumed
//   div_annul_i        - cancel in-flight divide
//   signed_div_i       - 1 = DIV, 0 = DIVU
//   opdata1_i/2_i      - dividend / divisor
//   div_result_o       - {remainder, quotient}
//   div_ready_o        - result valid
//   busy_o             - stall request
// Build option: define HILO_DIV_EN to include the divider; otherwise
// only HI/LO exist and all divider outputs are tied to zero.
module hilo_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    input  logic        div_start_i,
    input  logic        div_annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] div_result_o,
    output logic        div_ready_o,
    output logic        busy_o
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_i) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

`ifdef HILO_DIV_EN

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] partial;
    logic [32:0] diff;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Magnitudes only for signed divides; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        mag1 = opdata1_i;
        mag2 = opdata2_i;
        if (signed_div_i && opdata1_i[31]) mag1 = 32'd0 - opdata1_i;
        if (signed_div_i && opdata2_i[31]) mag2 = 32'd0 - opdata2_i;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    always_comb begin
        partial = {rem_q, quo_q[31]};
        diff    = partial - {1'b0, dsr_q};
        if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    assign quo_fix = qneg_q ? (32'd0 - quo_q) : quo_q;
    assign rem_fix = rneg_q ? (32'd0 - rem_q) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_start_i && !div_annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= mag1;
                            dsr_q   <= mag2;
                            qneg_q  <= signed_div_i &
                                       (opdata1_i[31] ^ opdata2_i[31]);
                            rneg_q  <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    if (div_annul_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_END;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (div_annul_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q != 6'd32) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        state_q  <= S_END;
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                    end
                end
                S_END: begin
                    if (!div_start_i) begin
                        state_q  <= S_IDLE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_result_o = result_q;
    assign div_ready_o  = ready_q;
    assign busy_o = (state_q == S_ON) || (state_q == S_BYZERO) ||
                    ((state_q == S_IDLE) && div_start_i && !div_annul_i);

`else

    logic unused_div;
    assign unused_div = ^{div_start_i, div_annul_i, signed_div_i,
                          opdata1_i, opdata2_i};

    assign div_result_o = '0;
    assign div_ready_o  = 1'b0;
    assign busy_o       = 1'b0;

`endif

endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: directed self-checking bench for hilo_div.
// Divider checks apply when HILO_DIV_EN is defined; otherwise tied-off outputs are checked.
module tb_hilo_div;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_start_i;
    logic        div_annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] div_result_o;
    logic        div_ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    hilo_div dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .div_start_i (div_start_i),
        .div_annul_i (div_annul_i),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .div_result_o(div_result_o),
        .div_ready_o (div_ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef HILO_DIV_EN
    // Hold start until ready, count edges from the sampling edge, then
    // drop start and confirm the unit clears. Operands are scrambled
    // after sampling; optionally a HI/LO write is pulsed mid-divide.
    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_n, input logic [63:0] exp_r,
                           input logic do_we);
        int  n;
        logic busy_ok;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        div_start_i  = 1'b1;
        #1;
        chk({tag, "_busy_idle"}, {63'd0, busy_o}, 64'd1);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            opdata1_i    = 32'hDEAD_BEEF;
            opdata2_i    = 32'h0000_0001;
            signed_div_i = ~sgn;
            if (do_we && n == 5) begin
                we_i = 1'b1;
                hi_i = 32'hCAFE_0001;
                lo_i = 32'hCAFE_0002;
            end
            if (do_we && n == 6) begin
                we_i = 1'b0;
                chk({tag, "_we_hi"}, {32'd0, hi_o}, {32'd0, 32'hCAFE_0001});
                chk({tag, "_we_lo"}, {32'd0, lo_o}, {32'd0, 32'hCAFE_0002});
            end
            if (div_ready_o) break;
            if (!busy_o) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_result"}, div_result_o, exp_r);
        chk({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_busy_end"}, {63'd0, busy_o}, 64'd0);
        tick();
        chk({tag, "_hold"}, div_result_o, exp_r);
        div_start_i = 1'b0;
        tick();
        chk({tag, "_rdy_clr"}, {63'd0, div_ready_o}, 64'd0);
        chk({tag, "_res_clr"}, div_result_o, 64'd0);
    endtask
`endif

    initial begin
        rst          = 1'b1;
        we_i         = 1'b0;
        hi_i         = '0;
        lo_i         = '0;
        div_start_i  = 1'b0;
        div_annul_i  = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_rdy", {63'd0, div_ready_o}, 64'd0);
        chk("rst_res", div_result_o, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);

        we_i = 1'b1;
        hi_i = 32'h1234_5678;
        lo_i = 32'h9ABC_DEF0;
        tick();
        we_i = 1'b0;
        chk("we_hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
        chk("we_lo", {32'd0, lo_o}, {32'd0, 32'h9ABC_DEF0});
        hi_i = 32'h1111_1111;
        lo_i = 32'h2222_2222;
        tick();
        chk("nowe_hi", {32'd0, hi_o}, {32'd0, 32'h1234_5678});
        rst  = 1'b1;
        we_i = 1'b1;
        tick();
        rst  = 1'b0;
        we_i = 1'b0;
        chk("rstwe_hi", {32'd0, hi_o}, 64'd0);
        chk("rstwe_lo", {32'd0, lo_o}, 64'd0);

`ifdef HILO_DIV_EN
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34,
                {32'h0000_0002, 32'h0000_000E}, 1'b1);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34,
                {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34,
                {32'h0000_0000, 32'hFFFF_FFFF}, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
                {32'h0000_0000, 32'h8000_0000}, 1'b0);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, 2, 64'd0, 1'b0);

        // Annul at counter 10: sampling edge, then ten stepping edges.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        div_start_i  = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("annul_busy_on", {63'd0, busy_o}, 64'd1);
        div_annul_i = 1'b1;
        div_start_i = 1'b0;
        tick();
        div_annul_i = 1'b0;
        chk("annul_busy", {63'd0, busy_o}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (div_ready_o) seen = 1'b1;
            end
            chk("annul_no_rdy", {63'd0, seen}, 64'd0);
        end
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 34,
                {32'h0, 32'h3}, 1'b0);

        // Reset mid-divide aborts with no result.
        opdata1_i   = 32'd50;
        opdata2_i   = 32'd5;
        div_start_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst         = 1'b1;
        div_start_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstdiv_busy", {63'd0, busy_o}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (div_ready_o) seen = 1'b1;
            end
            chk("rstdiv_no_rdy", {63'd0, seen}, 64'd0);
        end
`else
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        div_start_i  = 1'b1;
        #1;
        chk("off_busy0", {63'd0, busy_o}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (div_ready_o || busy_o || div_result_o != 64'd0)
                    seen = 1'b1;
            end
            chk("off_quiet", {63'd0, seen}, 64'd0);
        end
        we_i = 1'b1;
        hi_i = 32'hA5A5_0000;
        lo_i = 32'h0000_5A5A;
        tick();
        we_i        = 1'b0;
        div_start_i = 1'b0;
        chk("off_we_hi", {32'd0, hi_o}, {32'd0, 32'hA5A5_0000});
        chk("off_we_lo", {32'd0, lo_o}, {32'd0, 32'h0000_5A5A});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
